// File: rtl/map_pkg.sv
// ---------------------------------------------------------------------------
// map_pkg
// Shared types and constants for the writable map RAM.
//   state_t             : fill / serve state of the map RAM
//   MAP_BOX/MAZE/ZERO   : selectable built-in layouts (INIT_MODE values)
//   ROWS/COLS           : grid size for the default 4-bit row/col addressing
// ---------------------------------------------------------------------------
package map_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int unsigned MAP_BOX  = 0;
    localparam int unsigned MAP_MAZE = 1;
    localparam int unsigned MAP_ZERO = 2;

    localparam int unsigned DEF_ROW_BITS = 4;
    localparam int unsigned DEF_COL_BITS = 4;
    localparam int unsigned DEF_BITS     = 2;

    localparam int unsigned ROWS = 2 ** DEF_ROW_BITS;
    localparam int unsigned COLS = 2 ** DEF_COL_BITS;

endpackage

// File: rtl/map_ram_if.sv
// ---------------------------------------------------------------------------
// map_ram_if
// Bus bundle between the map RAM and its users (ray tracer read side and
// host/SPI write side).
//   init_req                 : pulse, restart the fill sequence
//   ready                    : map valid, read/write ports live
//   rd_en/rd_row/rd_col      : read request
//   rd_val/rd_valid          : registered read data, 1-cycle latency
//   wr_en/wr_row/wr_col/wr_val : cell write request
// master = host/tracer side, slave = map_ram.
// ---------------------------------------------------------------------------
interface map_ram_if
    import map_pkg::*;
#(
    parameter int unsigned ROW_BITS = DEF_ROW_BITS,
    parameter int unsigned COL_BITS = DEF_COL_BITS,
    parameter int unsigned BITS     = DEF_BITS
);

    logic                init_req;
    logic                ready;
    logic                rd_en;
    logic [ROW_BITS-1:0] rd_row;
    logic [COL_BITS-1:0] rd_col;
    logic [BITS-1:0]     rd_val;
    logic                rd_valid;
    logic                wr_en;
    logic [ROW_BITS-1:0] wr_row;
    logic [COL_BITS-1:0] wr_col;
    logic [BITS-1:0]     wr_val;

    modport master (
        output init_req, rd_en, rd_row, rd_col, wr_en, wr_row, wr_col, wr_val,
        input  ready, rd_val, rd_valid
    );

    modport slave (
        input  init_req, rd_en, rd_row, rd_col, wr_en, wr_row, wr_col, wr_val,
        output ready, rd_val, rd_valid
    );

endinterface

// File: rtl/map_pattern_gen.sv
// ---------------------------------------------------------------------------
// map_pattern_gen
// Combinational built-in layout: returns the fill value of cell (row, col).
//   i_row   : row address
//   i_col   : column address
//   o_val_c : WALL_VAL for wall cells, 0 otherwise
// INIT_MODE selects outer box, box plus maze, or an empty map.
// ---------------------------------------------------------------------------
module map_pattern_gen
    import map_pkg::*;
#(
    parameter int unsigned   ROW_BITS  = DEF_ROW_BITS,
    parameter int unsigned   COL_BITS  = DEF_COL_BITS,
    parameter int unsigned   BITS      = DEF_BITS,
    parameter int unsigned   INIT_MODE = MAP_MAZE,
    parameter logic [BITS-1:0] WALL_VAL = '1
) (
    input  logic [ROW_BITS-1:0] i_row,
    input  logic [COL_BITS-1:0] i_col,
    output logic [BITS-1:0]     o_val_c
);

    localparam logic [ROW_BITS-1:0] ROW_LAST = '1;
    localparam logic [COL_BITS-1:0] COL_LAST = '1;

    logic w_box;
    logic w_maze;

    // Outer boundary of the grid
    assign w_box = (i_row == '0) || (i_row == ROW_LAST) ||
                   (i_col == '0) || (i_col == COL_LAST);

    generate
        if (INIT_MODE > MAP_ZERO) begin : g_bad_mode
            $error("map_pattern_gen: INIT_MODE must be 0, 1 or 2");
        end

        if (INIT_MODE == MAP_MAZE) begin : g_maze
            if ((ROW_BITS < 4) || (COL_BITS < 4)) begin : g_too_small
                $error("map_pattern_gen: maze layout needs ROW_BITS>=4 and COL_BITS>=4");
                assign w_maze = 1'b0;
            end else begin : g_terms
                logic w_diag;
                logic w_mix;

                // Anti-diagonal inside the top-left 8x8 quadrant
                assign w_diag = (~i_row[2:0] == i_col[2:0]) && !i_row[3] && !i_col[3];

                // Scattered wall segments, masked to alternating 4-wide bands
                assign w_mix = ((((i_row[1] ^ i_col[2]) ^ (i_row[0] & i_col[1]))
                                 & i_row[2] & i_col[1])
                                | (~i_row[0] & ~i_col[0]))
                               & (i_row[2] ^ ~i_col[2]);

                assign w_maze = w_diag | w_mix;
            end
        end else begin : g_no_maze
            assign w_maze = 1'b0;
        end
    endgenerate

    // Empty map ignores both terms
    always_comb begin
        o_val_c = '0;
        if ((INIT_MODE != MAP_ZERO) && (w_box || w_maze)) begin
            o_val_c = WALL_VAL;
        end
    end

endmodule

// File: rtl/map_ram.sv
// ---------------------------------------------------------------------------
// map_ram
// Writable ROWS x COLS map of BITS-wide cells held in registers.
// After reset or init_req it walks every cell once, loading the built-in
// layout, then raises ready and serves reads/writes.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : map_ram_if.slave (init_req, ready, read port, write port)
// Read data is registered (1-cycle latency); a same-cycle write to the
// read cell is seen by the following read only.
// ---------------------------------------------------------------------------
module map_ram
    import map_pkg::*;
#(
    parameter int unsigned     ROW_BITS  = DEF_ROW_BITS,
    parameter int unsigned     COL_BITS  = DEF_COL_BITS,
    parameter int unsigned     BITS      = DEF_BITS,
    parameter int unsigned     INIT_MODE = MAP_MAZE,
    parameter logic [BITS-1:0] WALL_VAL  = '1
) (
    input  logic      clk,
    input  logic      reset,
    map_ram_if.slave  bus
);

    localparam int unsigned ADDR_BITS = ROW_BITS + COL_BITS;
    localparam int unsigned CELLS     = 2 ** ADDR_BITS;

    typedef logic [ADDR_BITS-1:0] addr_t;

    localparam addr_t ADDR_LAST = '1;

    state_t          r_state;
    state_t          w_state_nxt;
    addr_t           r_cnt;
    addr_t           w_cnt_nxt;
    logic            r_ready;
    logic            r_rd_valid;
    logic [BITS-1:0] r_rd_val;
    logic [BITS-1:0] r_mem [CELLS];

    logic            w_fill_we;
    logic            w_host_we;
    logic            w_rd_fire;
    logic [BITS-1:0] w_pat_val;
    addr_t           w_rd_addr;
    addr_t           w_wr_addr;

    assign w_rd_addr = {bus.rd_row, bus.rd_col};
    assign w_wr_addr = {bus.wr_row, bus.wr_col};

    // Layout value for the cell currently addressed by the fill counter
    map_pattern_gen #(
        .ROW_BITS  (ROW_BITS),
        .COL_BITS  (COL_BITS),
        .BITS      (BITS),
        .INIT_MODE (INIT_MODE),
        .WALL_VAL  (WALL_VAL)
    ) u_pattern (
        .i_row   (r_cnt[ADDR_BITS-1:COL_BITS]),
        .i_col   (r_cnt[COL_BITS-1:0]),
        .o_val_c (w_pat_val)
    );

    // Next-state, fill counter and port enables
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fill_we   = 1'b0;
        w_host_we   = 1'b0;
        w_rd_fire   = r_ready & bus.rd_en;

        case (r_state)
            FILL: begin
                w_fill_we = 1'b1;
                if (bus.init_req) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = addr_t'(r_cnt + 1'b1);
                    if (r_cnt == ADDR_LAST) begin
                        w_state_nxt = READY;
                    end
                end
            end
            READY: begin
                // init_req wins over a same-cycle host write
                if (bus.init_req) begin
                    w_state_nxt = FILL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_host_we = bus.wr_en;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FILL;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_val   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ready    <= (w_state_nxt == READY);
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_val <= r_mem[w_rd_addr];
            end
        end
    end

    // Cell storage; contents are only meaningful once a fill has completed
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_fill_we) begin
                r_mem[r_cnt] <= w_pat_val;
            end else if (w_host_we) begin
                r_mem[w_wr_addr] <= bus.wr_val;
            end
        end
    end

    assign bus.ready    = r_ready;
    assign bus.rd_val   = r_rd_val;
    assign bus.rd_valid = r_rd_valid;

endmodule
